// File: rtl/uart_tx_fifo_ctrl.sv
//-----------------------------------------------------------------------------
// uart_tx_fifo_ctrl
//
// Byte FIFO controller in front of a UART transmitter. The producer pushes
// 1..ENTRY_WIDTH bytes per cycle into an external byte-addressed memory. A
// three-state read FSM then streams the stored bytes, one at a time, to the
// transmitter.
//
// Memory byte placement: a push of width W writes byte k of mem_data_in to
// address (mem_write_addr + W-1-k) mod DEPTH. Because the read side walks
// addresses upward, byte W-1 of the push goes out first and byte 0 goes out
// last.
//
// Handshakes:
//   Push side: a push is accepted in any cycle where push_valid and push_ready
//   are both high. push_ready depends only on push_width and the registered
//   count, never on push_valid.
//   Tx side: a byte is transferred in any cycle where tx_valid and tx_ready
//   are both high. tx_valid never depends on tx_ready, and tx_data stays
//   stable while tx_valid is high.
//
// Optional feature: define UART_FIFO_LEVEL_EN to add the fifo_level output,
// which carries the registered byte count.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push_valid/ready  push handshake
//   push_width        bytes in this push (1..ENTRY_WIDTH)
//   push_data         push payload; the low push_width bytes are valid
//   mem_write_*       combinational write port to the external memory
//   mem_read_addr     read address (= rd_ptr)
//   mem_data_out      memory read data, one cycle after the address
//   tx_data/valid     byte offered to the transmitter
//   tx_ready          transmitter accepts the byte
//   fifo_level        registered count (only with UART_FIFO_LEVEL_EN)
//   rd_state          read FSM state, for debug and checkers
//-----------------------------------------------------------------------------
module uart_tx_fifo_ctrl #(
    parameter int DEPTH       = 64,
    parameter int ENTRY_WIDTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int WW = $clog2(ENTRY_WIDTH) + 1,
    localparam int CW = AW + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [WW-1:0]            push_width,
    input  logic [ENTRY_WIDTH*8-1:0] push_data,
    output logic                     push_ready,
    output logic                     mem_write_enable,
    output logic [WW-1:0]            mem_write_width,
    output logic [AW-1:0]            mem_write_addr,
    output logic [ENTRY_WIDTH*8-1:0] mem_data_in,
    output logic [AW-1:0]            mem_read_addr,
    input  logic [7:0]               mem_data_out,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
`ifdef UART_FIFO_LEVEL_EN
    output logic [CW-1:0]            fifo_level,
`endif
    output logic [1:0]               rd_state
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic          width_ok;
    logic          push_fire;
    logic          pop;
    logic [CW-1:0] free_space;
    logic [CW-1:0] push_width_ext;
    logic [CW-1:0] add_amt;
    logic [CW-1:0] sub_amt;

    // Zero and oversize widths are rejected outright, even when there is
    // room for them.
    assign push_width_ext = CW'(push_width);
    assign free_space     = CW'(DEPTH) - count_q;
    assign width_ok       = (push_width != '0) && (push_width <= WW'(ENTRY_WIDTH));
    assign push_ready     = width_ok && (free_space >= push_width_ext);
    assign push_fire      = push_valid && push_ready;

    assign mem_write_enable = push_fire;
    assign mem_write_addr   = wr_ptr_q;
    assign mem_write_width  = push_width;
    assign mem_data_in      = push_data;
    assign mem_read_addr    = rd_ptr_q;

    assign pop = (state_q == ST_VALID) && tx_ready;

    // Push and pop in the same cycle are applied together. push_ready is
    // computed from the pre-pop count, so this sum never exceeds DEPTH.
    assign add_amt = push_fire ? push_width_ext : '0;
    assign sub_amt = pop ? CW'(1) : '0;
    assign count_d = count_q + add_amt - sub_amt;

    // Truncating the width to AW bits keeps the pointer arithmetic modulo
    // DEPTH, including the case ENTRY_WIDTH == DEPTH.
    assign wr_ptr_d = push_fire ? (wr_ptr_q + AW'(push_width)) : wr_ptr_q;

    // Read FSM. EMPTY looks only at the registered count, so a byte written
    // this cycle is never fetched before the memory holds it. FETCH exists
    // to absorb the memory's one-cycle read latency.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        rd_ptr_d  = rd_ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (count_q != '0) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                tx_data_d = mem_data_out;
                state_d   = ST_VALID;
            end
            ST_VALID: begin
                if (tx_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    state_d  = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_EMPTY;
            tx_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_valid = (state_q == ST_VALID);
    assign tx_data  = tx_data_q;
    assign rd_state = state_q;

`ifdef UART_FIFO_LEVEL_EN
    assign fifo_level = count_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
module tb_uart_tx_fifo_ctrl;

    localparam int DEPTH = 64;
    localparam int EW    = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = $clog2(EW) + 1;
    localparam int CW    = AW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              push_valid;
    logic [WW-1:0]     push_width;
    logic [EW*8-1:0]   push_data;
    logic              push_ready;
    logic              mem_write_enable;
    logic [WW-1:0]     mem_write_width;
    logic [AW-1:0]     mem_write_addr;
    logic [EW*8-1:0]   mem_data_in;
    logic [AW-1:0]     mem_read_addr;
    logic [7:0]        mem_data_out;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [1:0]        rd_state;
`ifdef UART_FIFO_LEVEL_EN
    logic [CW-1:0]     fifo_level;
`endif

    uart_tx_fifo_ctrl #(.DEPTH(DEPTH), .ENTRY_WIDTH(EW)) dut (
        .clk              (clk),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_width       (push_width),
        .push_data        (push_data),
        .push_ready       (push_ready),
        .mem_write_enable (mem_write_enable),
        .mem_write_width  (mem_write_width),
        .mem_write_addr   (mem_write_addr),
        .mem_data_in      (mem_data_in),
        .mem_read_addr    (mem_read_addr),
        .mem_data_out     (mem_data_out),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
`ifdef UART_FIFO_LEVEL_EN
        .fifo_level       (fifo_level),
`endif
        .rd_state         (rd_state)
    );

    // ---------------- external byte memory ----------------
    // Byte k of a width-W write lands at addr + W-1-k, so the highest valid
    // byte sits at the lowest address and is read out first.
    logic [7:0] mem [DEPTH];
    int         wr_hits [DEPTH];

    function automatic int byte_addr(input int base, input int w, input int k);
        return (base + w - 1 - k) % DEPTH;
    endfunction

    always @(posedge clk) begin
        if (mem_write_enable === 1'b1) begin
            for (int k = 0; k < EW; k++) begin
                if (k < int'(mem_write_width)) begin
                    mem[byte_addr(int'(mem_write_addr), int'(mem_write_width), k)] <= mem_data_in[8*k +: 8];
                    wr_hits[byte_addr(int'(mem_write_addr), int'(mem_write_width), k)] <=
                        wr_hits[byte_addr(int'(mem_write_addr), int'(mem_write_width), k)] + 1;
                end
            end
        end
        mem_data_out <= mem[mem_read_addr];
    end

    // ---------------- scoreboard / reference model ----------------
    logic [7:0] exp_q[$];
    int         wr_cnt;
    int         rd_cnt;
    int         idle;
    int         errors;
    int         checks;
    bit         last_tx_valid;
    bit         last_pop;
    logic [7:0] last_pop_byte;
    logic [31:0] collected;
    int         n_popped;
    int         lat;
    int         need;
    int         hits_before [DEPTH];
    logic [63:0] hit_vec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge: compares outputs with the byte-queue model,
    // then applies what the next rising edge will do to the model.
    task automatic model_step();
        int  w;
        int  free;
        bit  exp_ready;
        w         = int'(push_width);
        free      = DEPTH - exp_q.size();
        exp_ready = (w >= 1) && (w <= EW) && (free >= w);
        chk("push_ready", {63'd0, push_ready}, {63'd0, exp_ready});
        chk("mem_we", {63'd0, mem_write_enable}, {63'd0, push_valid && exp_ready});
        chk("wr_addr", 64'(mem_write_addr), 64'(wr_cnt % DEPTH));
        chk("rd_addr", 64'(mem_read_addr), 64'(rd_cnt % DEPTH));
        if (push_valid && exp_ready) begin
            chk("wr_width", 64'(mem_write_width), 64'(push_width));
            chk("wr_data", 64'(mem_data_in), 64'(push_data));
        end
`ifdef UART_FIFO_LEVEL_EN
        chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
`endif
        if (exp_q.size() == 0) begin
            chk("tx_valid_empty", {63'd0, tx_valid}, 64'd0);
        end else if (tx_valid === 1'b1) begin
            chk("tx_data", 64'(tx_data), 64'(exp_q[0]));
        end
        if (exp_q.size() != 0 && tx_valid !== 1'b1) begin
            idle++;
            if (idle > 2) chk("tx_latency", {63'd0, tx_valid}, 64'd1);
        end else begin
            idle = 0;
        end
        last_tx_valid = (tx_valid === 1'b1);
        last_pop      = 1'b0;
        if (tx_valid === 1'b1 && tx_ready) begin
            last_pop      = 1'b1;
            last_pop_byte = tx_data;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            rd_cnt++;
        end
        if (push_valid && exp_ready) begin
            for (int k = w - 1; k >= 0; k--) exp_q.push_back(push_data[8*k +: 8]);
            wr_cnt += w;
        end
        if (reset) begin
            exp_q.delete();
            wr_cnt = 0;
            rd_cnt = 0;
            idle   = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input int w, input logic [31:0] d);
        push_valid = 1'b1;
        push_width = WW'(w);
        push_data  = d;
        cycle();
        push_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        push_valid = 1'b0;
        tx_ready   = 1'b1;
        for (int i = 0; i < limit && exp_q.size() != 0; i++) begin
            cycle();
            if (last_pop) begin
                collected = {collected[23:0], last_pop_byte};
                n_popped++;
            end
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 5; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        errors = 0; checks = 0; wr_cnt = 0; rd_cnt = 0; idle = 0;
        last_tx_valid = 1'b0; last_pop = 1'b0; last_pop_byte = '0;
        collected = '0; n_popped = 0; lat = 0; need = 0;
        reset = 1'b1; push_valid = 1'b0; push_width = WW'(4);
        push_data = '0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_rd_addr", 64'(mem_read_addr), 64'd0);
        chk("rst_wr_addr", 64'(mem_write_addr), 64'd0);
        chk("rst_ready_w4", {63'd0, push_ready}, 64'd1);
        model_step();
        @(posedge clk); #1;

        // Width-4 push, streamed out most-significant byte first
        collected = '0; n_popped = 0;
        tx_ready = 1'b1;
        push1(4, 32'h41424344);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            cycle();
            if (last_tx_valid) lat = i;
            if (last_pop) begin
                collected = {collected[23:0], last_pop_byte};
                n_popped++;
            end
        end
        chk("first_latency", 64'(lat), 64'd3);
        drain(40);
        chk("order_41424344", 64'(collected), 64'h41424344);

        // Illegal widths are refused and leave the pointers alone
        push_valid = 1'b1; push_width = WW'(0); push_data = 32'h11223344;
        @(negedge clk);
        chk("w0_ready", {63'd0, push_ready}, 64'd0);
        chk("w0_we", {63'd0, mem_write_enable}, 64'd0);
        model_step(); @(posedge clk); #1;
        push_width = WW'(5);
        @(negedge clk);
        chk("w5_ready", {63'd0, push_ready}, 64'd0);
        chk("w5_we", {63'd0, mem_write_enable}, 64'd0);
        model_step(); @(posedge clk); #1;
        push_valid = 1'b0;
        @(negedge clk);
        chk("bad_w_wr_addr", 64'(mem_write_addr), 64'd4);
        chk("bad_w_rd_addr", 64'(mem_read_addr), 64'd4);
        model_step(); @(posedge clk); #1;

        // Fill to DEPTH with single bytes while the transmitter stalls
        tx_ready = 1'b0;
        for (int v = 0; v < DEPTH; v++) push1(1, 32'(v));
        push_valid = 1'b1; push_width = WW'(1); push_data = 32'h99;
        @(negedge clk);
        chk("full_ready_w1", {63'd0, push_ready}, 64'd0);
        chk("full_we", {63'd0, mem_write_enable}, 64'd0);
`ifdef UART_FIFO_LEVEL_EN
        chk("full_level", 64'(fifo_level), 64'd64);
`endif
        model_step(); @(posedge clk); #1;
        push_valid = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_valid", {63'd0, tx_valid}, 64'd1);
        chk("full_pop_data", 64'(tx_data), 64'd0);
        model_step(); @(posedge clk); #1;
        tx_ready = 1'b0; push_width = WW'(1);
        @(negedge clk);
        chk("one_free_w1", {63'd0, push_ready}, 64'd1);
        model_step(); @(posedge clk); #1;
        push_width = WW'(2);
        @(negedge clk);
        chk("one_free_w2", {63'd0, push_ready}, 64'd0);
        model_step(); @(posedge clk); #1;
        collected = '0; n_popped = 0;
        drain(400);
        chk("fill_drained", 64'(n_popped), 64'd63);
        chk("fill_tail", 64'(collected), 64'h3C3D3E3F);

        // Random traffic: a mostly-stalled phase then a mostly-draining phase
        for (int i = 0; i < 300; i++) begin
            push_valid = 1'($urandom_range(0, 1));
            push_width = WW'($urandom_range(0, 5));
            push_data  = $urandom;
            if (i < 150) tx_ready = ($urandom_range(0, 7) == 0);
            else         tx_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain(400);

        // Move wr_ptr to 62, then push across the wrap point
        need = (62 - (wr_cnt % DEPTH) + DEPTH) % DEPTH;
        tx_ready = 1'b0;
        while (need > 0) begin
            push1((need > EW) ? EW : need, $urandom);
            need -= (need > EW) ? EW : need;
        end
        drain(400);
        for (int a = 0; a < DEPTH; a++) hits_before[a] = wr_hits[a];
        collected = '0; n_popped = 0;
        tx_ready = 1'b0;
        push_valid = 1'b1; push_width = WW'(4); push_data = 32'hA1A2A3A4;
        @(negedge clk);
        chk("wrap_wr_addr", 64'(mem_write_addr), 64'd62);
        model_step(); @(posedge clk); #1;
        push_valid = 1'b0;
        drain(40);
        chk("wrap_order", 64'(collected), 64'hA1A2A3A4);
        for (int a = 0; a < DEPTH; a++) hit_vec[a] = (wr_hits[a] != hits_before[a]);
        chk("wrap_addrs", hit_vec, 64'hC000_0000_0000_0003);
        @(negedge clk);
        chk("wrap_wr_ptr", 64'(mem_write_addr), 64'd2);
        model_step(); @(posedge clk); #1;

        // Push of 2 in the same cycle as a pop with 5 stored
        tx_ready = 1'b0;
        push1(4, $urandom);
        push1(1, $urandom);
        for (int i = 0; i < 8 && !last_tx_valid; i++) cycle();
        tx_ready = 1'b1; push_valid = 1'b1; push_width = WW'(2); push_data = 32'hBEEF;
        @(negedge clk);
        chk("pp_valid", {63'd0, tx_valid}, 64'd1);
        chk("pp_ready", {63'd0, push_ready}, 64'd1);
        model_step(); @(posedge clk); #1;
        tx_ready = 1'b0; push_valid = 1'b0;
        @(negedge clk);
`ifdef UART_FIFO_LEVEL_EN
        chk("pp_level", 64'(fifo_level), 64'd6);
`endif
        model_step(); @(posedge clk); #1;
        collected = '0; n_popped = 0;
        drain(60);
        chk("pp_count", 64'(n_popped), 64'd6);

        // Reset while holding a byte in VALID with 10 stored
        tx_ready = 1'b0;
        push1(4, $urandom);
        push1(4, $urandom);
        push1(2, $urandom);
        for (int i = 0; i < 8 && !last_tx_valid; i++) cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid", {63'd0, tx_valid}, 64'd1);
`ifdef UART_FIFO_LEVEL_EN
        chk("pre_rst_level", 64'(fifo_level), 64'd10);
`endif
        model_step(); @(posedge clk); #1;
        reset = 1'b0; push_width = WW'(1);
        @(negedge clk);
        chk("post_rst_valid", {63'd0, tx_valid}, 64'd0);
        chk("post_rst_ready", {63'd0, push_ready}, 64'd1);
        chk("post_rst_rd", 64'(mem_read_addr), 64'd0);
        chk("post_rst_wr", 64'(mem_write_addr), 64'd0);
`ifdef UART_FIFO_LEVEL_EN
        chk("post_rst_level", 64'(fifo_level), 64'd0);
`endif
        model_step(); @(posedge clk); #1;
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
